// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the IFU request/response, LSU request/response and shared memory
// port signals of mem_port_arbiter.
//
// Handshake semantics (all *_req channels): a transfer happens on a rising
// clk edge where vld && rdy are both high. A requester holds vld and payload
// stable until rdy; it may drop vld before rdy to cancel the request. rdy
// never depends combinationally on the requester's own payload. Response
// channels (*_rsp_vld) have no back-pressure: they are valid for exactly one
// cycle.
//
// Modports:
//   slave  : the arbiter's view (accepts IFU/LSU requests, drives memory).
//   master : the environment's view (IFU, LSU and memory models).
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_BYTE  = DATA_WIDTH / 8
);
  // IFU fetch channel
  logic                  ifu_req_vld;
  logic                  ifu_req_rdy;
  logic [ADDR_WIDTH-1:0] ifu_req_addr;
  logic                  ifu_rsp_vld;
  logic [DATA_WIDTH-1:0] ifu_rsp_data;

  // LSU load/store channel
  logic                  lsu_req_vld;
  logic                  lsu_req_rdy;
  logic                  lsu_req_we;
  logic [ADDR_WIDTH-1:0] lsu_req_addr;
  logic [DATA_WIDTH-1:0] lsu_req_data;
  logic [DATA_BYTE-1:0]  lsu_req_strb;
  logic                  lsu_rsp_vld;
  logic [DATA_WIDTH-1:0] lsu_rsp_data;

  // Shared memory port
  logic                  mem_req_vld;
  logic                  mem_req_rdy;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_data;
  logic [DATA_BYTE-1:0]  mem_req_strb;
  logic                  mem_rsp_vld;
  logic [DATA_WIDTH-1:0] mem_rsp_data;

  modport slave (
    input  ifu_req_vld, ifu_req_addr,
    output ifu_req_rdy, ifu_rsp_vld, ifu_rsp_data,
    input  lsu_req_vld, lsu_req_we, lsu_req_addr, lsu_req_data, lsu_req_strb,
    output lsu_req_rdy, lsu_rsp_vld, lsu_rsp_data,
    output mem_req_vld, mem_req_we, mem_req_addr, mem_req_data, mem_req_strb,
    input  mem_req_rdy, mem_rsp_vld, mem_rsp_data
  );

  modport master (
    output ifu_req_vld, ifu_req_addr,
    input  ifu_req_rdy, ifu_rsp_vld, ifu_rsp_data,
    output lsu_req_vld, lsu_req_we, lsu_req_addr, lsu_req_data, lsu_req_strb,
    input  lsu_req_rdy, lsu_rsp_vld, lsu_rsp_data,
    input  mem_req_vld, mem_req_we, mem_req_addr, mem_req_data, mem_req_strb,
    output mem_req_rdy, mem_rsp_vld, mem_rsp_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the core's single memory port between the IFU fetch requester and
// the LSU load/store requester. The granted request is registered onto the
// memory port; an owner FIFO remembers who issued each outstanding
// transaction so in-order memory responses are routed back to the issuer.
// LSU has priority; after STARVE_LIMIT consecutive denied IFU cycles the IFU
// wins arbitration.
//
// Ports:
//   clk, rst         core clock, asynchronous active-high reset
//   bus              mem_port_arbiter_if.slave (IFU, LSU and memory channels)
//   outstanding_cnt  number of issued transactions awaiting a response
//   err_unexp_rsp    sticky: a response arrived with no outstanding owner
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_BYTE       = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  mem_port_arbiter_if.slave                  bus,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_cnt,
  output logic                               err_unexp_rsp
);

  localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W  = PTR_W + 1;
  // One extra bit so count + in-flight slot can never wrap in the compare.
  localparam int OCC_W  = PTR_W + 2;
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [OCC_W-1:0]  MAX_OCC   = OCC_W'(MAX_OUTSTANDING);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(STARVE_LIMIT);

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  // Memory request output register
  logic                  req_vld_q,   req_vld_d;
  logic                  req_we_q,    req_we_d;
  logic [ADDR_WIDTH-1:0] req_addr_q,  req_addr_d;
  logic [DATA_WIDTH-1:0] req_data_q,  req_data_d;
  logic [DATA_BYTE-1:0]  req_strb_q,  req_strb_d;
  logic                  req_owner_q, req_owner_d;

  // Owner FIFO
  logic [MAX_OUTSTANDING-1:0] owner_fifo_q, owner_fifo_d;
  logic [PTR_W-1:0]           wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q,     rd_ptr_d;
  logic [CNT_W-1:0]           cnt_q,        cnt_d;

  // Starvation counter and error flag
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q,  err_d;

  logic             slot_free;
  logic [OCC_W-1:0] occupancy;
  logic             can_issue;
  logic             starved;
  logic             grant_lsu;
  logic             grant_ifu;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             head_owner;

  // ---------------------------------------------------------------------------
  // Arbitration. The slot counts toward occupancy because a request sitting in
  // the output register will be pushed into the owner FIFO when it hands off.
  // Only slot_free looks at mem_req_rdy, keeping the ready path short.
  // ---------------------------------------------------------------------------
  assign slot_free = !req_vld_q || bus.mem_req_rdy;
  assign occupancy = {1'b0, cnt_q} + OCC_W'(req_vld_q);
  assign can_issue = !rst && slot_free && (occupancy < MAX_OCC);
  assign starved   = (wait_q >= WAIT_SAT);

  assign grant_lsu = can_issue && bus.lsu_req_vld && !(starved && bus.ifu_req_vld);
  assign grant_ifu = can_issue && bus.ifu_req_vld && !grant_lsu;

  assign bus.ifu_req_rdy = grant_ifu;
  assign bus.lsu_req_rdy = grant_lsu;

  // ---------------------------------------------------------------------------
  // Owner FIFO bookkeeping and response routing
  // ---------------------------------------------------------------------------
  assign fifo_empty = (cnt_q == '0);
  assign push       = req_vld_q && bus.mem_req_rdy;
  assign pop        = bus.mem_rsp_vld && !fifo_empty;
  assign head_owner = owner_fifo_q[rd_ptr_q];

  assign bus.ifu_rsp_vld  = pop && (head_owner == OWNER_IFU);
  assign bus.lsu_rsp_vld  = pop && (head_owner == OWNER_LSU);
  assign bus.ifu_rsp_data = bus.mem_rsp_data;
  assign bus.lsu_rsp_data = bus.mem_rsp_data;

  assign bus.mem_req_vld  = req_vld_q;
  assign bus.mem_req_we   = req_we_q;
  assign bus.mem_req_addr = req_addr_q;
  assign bus.mem_req_data = req_data_q;
  assign bus.mem_req_strb = req_strb_q;

  assign outstanding_cnt = cnt_q;
  assign err_unexp_rsp   = err_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    req_vld_d   = req_vld_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_strb_d  = req_strb_q;
    req_owner_d = req_owner_q;

    if (grant_lsu) begin
      req_vld_d   = 1'b1;
      req_we_d    = bus.lsu_req_we;
      req_addr_d  = bus.lsu_req_addr;
      req_data_d  = bus.lsu_req_data;
      req_strb_d  = bus.lsu_req_strb;
      req_owner_d = OWNER_LSU;
    end else if (grant_ifu) begin
      req_vld_d   = 1'b1;
      req_we_d    = 1'b0;
      req_addr_d  = bus.ifu_req_addr;
      req_data_d  = '0;
      req_strb_d  = '0;
      req_owner_d = OWNER_IFU;
    end else if (bus.mem_req_rdy) begin
      // Handshake completed (or slot already empty) and nothing replaces it.
      req_vld_d = 1'b0;
    end
  end

  always_comb begin
    owner_fifo_d = owner_fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;

    if (push) begin
      owner_fifo_d[wr_ptr_q] = req_owner_q;
      wr_ptr_d               = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (!bus.ifu_req_vld || grant_ifu) begin
      wait_d = '0;
    end else if (wait_q < WAIT_SAT) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    err_d = err_q || (bus.mem_rsp_vld && fifo_empty);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_vld_q    <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      req_strb_q   <= '0;
      req_owner_q  <= OWNER_IFU;
      owner_fifo_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      wait_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      req_vld_q    <= req_vld_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      req_strb_q   <= req_strb_d;
      req_owner_q  <= req_owner_d;
      owner_fifo_q <= owner_fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios (single fetch, simultaneous requests, starvation, FIFO
// full with back-pressure, unexpected response, mid-operation reset) followed
// by randomized traffic, all checked every cycle against a transaction-level
// model: an owner queue, a one-entry pending-request slot and an IFU wait
// count derived from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int DB   = 4;
  localparam int MAXO = 4;
  localparam int SL   = 8;
  localparam int CW   = $clog2(MAXO) + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_BYTE(DB)) bus ();

  logic [CW-1:0] outstanding_cnt;
  logic          err_unexp_rsp;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_BYTE(DB),
    .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus.slave),
    .outstanding_cnt (outstanding_cnt),
    .err_unexp_rsp   (err_unexp_rsp)
  );

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DB-1:0] strb;
    logic          owner;  // 0 = IFU, 1 = LSU
  } req_t;

  logic [0:0] exp_q[$];    // owners of issued, unanswered transactions
  req_t       m_slot;      // request currently presented on the memory port
  bit         m_slot_vld;
  int         m_wait;
  bit         m_err;
  bit         acc_ifu, acc_lsu;

  // Observed combinational outputs of the last tick
  logic          obs_ifu_rdy, obs_lsu_rdy, obs_ifu_rsp, obs_lsu_rsp;
  logic [DW-1:0] obs_ifu_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_slot     = '0;
    m_slot_vld = 1'b0;
    m_wait     = 0;
    m_err      = 1'b0;
    acc_ifu    = 1'b0;
    acc_lsu    = 1'b0;
  endfunction

  // Called at a negedge after inputs are driven: checks the cycle, advances
  // the model as the coming posedge will, and returns on the next negedge.
  task automatic tick();
    bit can, starved, g_lsu, g_ifu, pop, push, head, e_ifu_rsp, e_lsu_rsp;
    int occ;
    #1;
    occ     = exp_q.size() + int'(m_slot_vld);
    can     = !rst && (!m_slot_vld || bus.mem_req_rdy) && (occ < MAXO);
    starved = (m_wait >= SL);
    g_lsu   = can && bus.lsu_req_vld && !(starved && bus.ifu_req_vld);
    g_ifu   = can && bus.ifu_req_vld && !g_lsu;
    head    = (exp_q.size() > 0) ? exp_q[0][0] : 1'b0;
    e_ifu_rsp = bus.mem_rsp_vld && (exp_q.size() > 0) && !head;
    e_lsu_rsp = bus.mem_rsp_vld && (exp_q.size() > 0) && head;

    check("ifu_req_rdy", bus.ifu_req_rdy, g_ifu);
    check("lsu_req_rdy", bus.lsu_req_rdy, g_lsu);
    check("mem_req_vld", bus.mem_req_vld, m_slot_vld);
    if (m_slot_vld) begin
      check("mem_req_we",   bus.mem_req_we,   m_slot.we);
      check("mem_req_addr", bus.mem_req_addr, m_slot.addr);
      check("mem_req_data", bus.mem_req_data, m_slot.data);
      check("mem_req_strb", bus.mem_req_strb, m_slot.strb);
    end
    check("outstanding_cnt", outstanding_cnt, exp_q.size());
    check("err_unexp_rsp",   err_unexp_rsp,   m_err);
    check("ifu_rsp_vld",     bus.ifu_rsp_vld, e_ifu_rsp);
    check("lsu_rsp_vld",     bus.lsu_rsp_vld, e_lsu_rsp);
    if (bus.mem_rsp_vld) begin
      check("ifu_rsp_data", bus.ifu_rsp_data, bus.mem_rsp_data);
      check("lsu_rsp_data", bus.lsu_rsp_data, bus.mem_rsp_data);
    end

    obs_ifu_rdy  = bus.ifu_req_rdy;
    obs_lsu_rdy  = bus.lsu_req_rdy;
    obs_ifu_rsp  = bus.ifu_rsp_vld;
    obs_lsu_rsp  = bus.lsu_rsp_vld;
    obs_ifu_data = bus.ifu_rsp_data;

    if (!rst) begin
      pop  = bus.mem_rsp_vld && (exp_q.size() > 0);
      push = m_slot_vld && bus.mem_req_rdy;
      if (bus.mem_rsp_vld && exp_q.size() == 0) m_err = 1'b1;
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(m_slot.owner);
      if (g_lsu) begin
        m_slot     = '{we: bus.lsu_req_we, addr: bus.lsu_req_addr, data: bus.lsu_req_data,
                       strb: bus.lsu_req_strb, owner: 1'b1};
        m_slot_vld = 1'b1;
      end else if (g_ifu) begin
        m_slot     = '{we: 1'b0, addr: bus.ifu_req_addr, data: '0, strb: '0, owner: 1'b0};
        m_slot_vld = 1'b1;
      end else if (bus.mem_req_rdy) begin
        m_slot_vld = 1'b0;
      end
      if (!bus.ifu_req_vld || g_ifu) m_wait = 0;
      else if (m_wait < SL)          m_wait = m_wait + 1;
    end
    acc_ifu = g_ifu;
    acc_lsu = g_lsu;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle();
    bus.ifu_req_vld  = 1'b0;
    bus.lsu_req_vld  = 1'b0;
    bus.lsu_req_we   = 1'b0;
    bus.mem_req_rdy  = 1'b1;
    bus.mem_rsp_vld  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while ((exp_q.size() > 0 || m_slot_vld) && n < 100) begin
      bus.mem_rsp_vld  = (exp_q.size() > 0);
      bus.mem_rsp_data = $urandom;
      tick();
      n++;
    end
    bus.mem_rsp_vld = 1'b0;
    check("drain_bound", (n < 100), 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    model_reset();
    tick();
    check("rst_mem_req_vld", bus.mem_req_vld, 1'b0);
    check("rst_cnt", outstanding_cnt, 0);
    check("rst_err", err_unexp_rsp, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic random_cycle(input int ifu_rate, input int lsu_rate,
                              input int rdy_rate, input int rsp_rate);
    bit drop;
    drop = 1'b0;
    if (acc_ifu) bus.ifu_req_vld = 1'b0;
    else if (bus.ifu_req_vld && $urandom_range(0, 19) == 0) begin
      bus.ifu_req_vld = 1'b0;
      drop = 1'b1;
    end
    if (!bus.ifu_req_vld && !drop && $urandom_range(0, 99) < ifu_rate) begin
      bus.ifu_req_vld  = 1'b1;
      bus.ifu_req_addr = $urandom & 32'hFFFF_FFFC;
    end
    drop = 1'b0;
    if (acc_lsu) bus.lsu_req_vld = 1'b0;
    else if (bus.lsu_req_vld && $urandom_range(0, 19) == 0) begin
      bus.lsu_req_vld = 1'b0;
      drop = 1'b1;
    end
    if (!bus.lsu_req_vld && !drop && $urandom_range(0, 99) < lsu_rate) begin
      bus.lsu_req_vld  = 1'b1;
      bus.lsu_req_we   = $urandom_range(0, 1);
      bus.lsu_req_addr = $urandom;
      bus.lsu_req_data = $urandom;
      bus.lsu_req_strb = DB'($urandom_range(0, 15));
    end
    bus.mem_req_rdy  = ($urandom_range(0, 99) < rdy_rate);
    bus.mem_rsp_vld  = (exp_q.size() > 0) && ($urandom_range(0, 99) < rsp_rate);
    bus.mem_rsp_data = $urandom;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int first_ifu, second_ifu, n_issued, loads_left;
    bit lsu_gr9;
    logic [AW-1:0] hold_addr;

    rst = 1'b1;
    bus.ifu_req_addr = '0;
    bus.lsu_req_addr = '0;
    bus.lsu_req_data = '0;
    bus.lsu_req_strb = '0;
    bus.mem_rsp_data = '0;
    idle();
    model_reset();
    @(negedge clk);
    do_reset();

    // Single fetch
    bus.ifu_req_vld  = 1'b1;
    bus.ifu_req_addr = 32'h100;
    tick();
    check("fetch_rdy_c0", obs_ifu_rdy, 1'b1);
    bus.ifu_req_vld = 1'b0;
    check("fetch_vld_c1",  bus.mem_req_vld,  1'b1);
    check("fetch_addr_c1", bus.mem_req_addr, 32'h100);
    check("fetch_we_c1",   bus.mem_req_we,   1'b0);
    check("fetch_cnt_c1",  outstanding_cnt,  0);
    tick();
    check("fetch_cnt_c2", outstanding_cnt, 1);
    tick();
    bus.mem_rsp_vld  = 1'b1;
    bus.mem_rsp_data = 32'hDEAD_BEEF;
    tick();
    check("fetch_rsp_vld",  obs_ifu_rsp,  1'b1);
    check("fetch_rsp_data", obs_ifu_data, 32'hDEAD_BEEF);
    check("fetch_lsu_quiet", obs_lsu_rsp, 1'b0);
    bus.mem_rsp_vld = 1'b0;
    check("fetch_cnt_c4", outstanding_cnt, 0);

    // Simultaneous requests: LSU first, then IFU, responses in order
    drain();
    bus.ifu_req_vld  = 1'b1;
    bus.ifu_req_addr = 32'h200;
    bus.lsu_req_vld  = 1'b1;
    bus.lsu_req_we   = 1'b1;
    bus.lsu_req_addr = 32'h300;
    bus.lsu_req_data = 32'h55;
    bus.lsu_req_strb = 4'h1;
    tick();
    check("sim_lsu_first", obs_lsu_rdy, 1'b1);
    check("sim_ifu_wait",  obs_ifu_rdy, 1'b0);
    bus.lsu_req_vld = 1'b0;
    check("sim_st_addr", bus.mem_req_addr, 32'h300);
    check("sim_st_we",   bus.mem_req_we,   1'b1);
    check("sim_st_data", bus.mem_req_data, 32'h55);
    check("sim_st_strb", bus.mem_req_strb, 4'h1);
    tick();
    check("sim_ifu_next", obs_ifu_rdy, 1'b1);
    bus.ifu_req_vld = 1'b0;
    check("sim_ld_addr", bus.mem_req_addr, 32'h200);
    check("sim_ld_strb", bus.mem_req_strb, 4'h0);
    tick();
    bus.mem_rsp_vld  = 1'b1;
    bus.mem_rsp_data = 32'h1111_2222;
    tick();
    check("sim_rsp1_lsu", obs_lsu_rsp, 1'b1);
    check("sim_rsp1_ifu", obs_ifu_rsp, 1'b0);
    tick();
    check("sim_rsp2_ifu", obs_ifu_rsp, 1'b1);
    check("sim_rsp2_lsu", obs_lsu_rsp, 1'b0);
    bus.mem_rsp_vld = 1'b0;

    // Starvation: IFU wins on its 9th valid cycle, then again 9 cycles later
    drain();
    first_ifu  = -1;
    second_ifu = -1;
    lsu_gr9    = 1'b0;
    bus.ifu_req_vld  = 1'b1;
    bus.ifu_req_addr = 32'h400;
    bus.lsu_req_vld  = 1'b1;
    bus.lsu_req_we   = 1'b0;
    bus.lsu_req_addr = 32'h2000;
    for (int c = 0; c < 24; c++) begin
      bus.mem_rsp_vld  = (exp_q.size() > 0);
      bus.mem_rsp_data = $urandom;
      tick();
      if (obs_ifu_rdy) begin
        if (first_ifu < 0) first_ifu = c;
        else if (second_ifu < 0) second_ifu = c;
        bus.ifu_req_addr = bus.ifu_req_addr + 32'd4;
      end
      if (obs_lsu_rdy) begin
        if (c == 9) lsu_gr9 = 1'b1;
        bus.lsu_req_addr = bus.lsu_req_addr + 32'd4;
      end
    end
    check("starve_first_grant",  first_ifu,  8);
    check("starve_lsu_resumes",  lsu_gr9,    1'b1);
    check("starve_second_grant", second_ifu, 17);

    // FIFO full: 6 loads, no responses, only 4 issue
    drain();
    n_issued   = 0;
    loads_left = 6;
    bus.lsu_req_vld  = 1'b1;
    bus.lsu_req_we   = 1'b0;
    bus.lsu_req_addr = 32'h1000;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (obs_lsu_rdy) begin
        n_issued++;
        loads_left--;
        bus.lsu_req_addr = bus.lsu_req_addr + 32'd4;
        if (loads_left == 0) bus.lsu_req_vld = 1'b0;
      end
    end
    check("full_issued", n_issued, 4);
    check("full_cnt", outstanding_cnt, 4);
    check("full_rdy_low", obs_lsu_rdy, 1'b0);
    bus.mem_req_rdy  = 1'b0;
    bus.mem_rsp_vld  = 1'b1;
    bus.mem_rsp_data = $urandom;
    tick();
    check("full_no_issue_on_pop", obs_lsu_rdy, 1'b0);
    bus.mem_rsp_vld = 1'b0;
    hold_addr = bus.lsu_req_addr;
    tick();
    check("full_refill", obs_lsu_rdy, 1'b1);
    if (obs_lsu_rdy) begin
      n_issued++;
      bus.lsu_req_addr = bus.lsu_req_addr + 32'd4;
    end
    for (int c = 0; c < 4; c++) begin
      check("hold_vld",  bus.mem_req_vld,  1'b1);
      check("hold_addr", bus.mem_req_addr, hold_addr);
      tick();
      check("hold_rdy_low", obs_lsu_rdy, 1'b0);
    end
    bus.mem_req_rdy = 1'b1;
    tick();
    check("full_issued_total", n_issued, 5);
    check("full_cnt_again", outstanding_cnt, 4);

    // Unexpected response, then reset mid-transfer
    drain();
    bus.mem_rsp_vld  = 1'b1;
    bus.mem_rsp_data = 32'hBAD0_BAD0;
    tick();
    check("unexp_no_ifu_rsp", obs_ifu_rsp, 1'b0);
    check("unexp_no_lsu_rsp", obs_lsu_rsp, 1'b0);
    bus.mem_rsp_vld = 1'b0;
    check("unexp_err_set", err_unexp_rsp, 1'b1);
    for (int c = 0; c < 3; c++) tick();
    check("unexp_err_sticky", err_unexp_rsp, 1'b1);

    bus.lsu_req_vld  = 1'b1;
    bus.lsu_req_addr = 32'h3000;
    tick();
    bus.lsu_req_addr = 32'h3004;
    tick();
    bus.mem_req_rdy = 1'b0;
    bus.lsu_req_vld = 1'b0;
    tick();
    check("pre_rst_cnt", outstanding_cnt, 1);
    do_reset();
    bus.mem_rsp_vld = 1'b1;
    tick();
    bus.mem_rsp_vld = 1'b0;
    check("post_rst_unexp_err", err_unexp_rsp, 1'b1);
    do_reset();

    // Randomized traffic
    for (int blk = 0; blk < 6; blk++) begin
      int ir, lr, rr, sr;
      ir = $urandom_range(10, 90);
      lr = $urandom_range(10, 90);
      rr = $urandom_range(30, 100);
      sr = $urandom_range(20, 90);
      for (int c = 0; c < 500; c++) random_cycle(ir, lr, rr, sr);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
